// File: rtl/axi_rd_arb.sv
// Round-robin AR arbiter for NUM_MST read masters sharing one AXI read channel.
// AR goes through a single-entry register; R beats are routed back by the ID prefix.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module axi_rd_arb #(
  parameter int NUM_MST = 4,
  parameter int SEL_W   = $clog2(NUM_MST),
  parameter int OST_MAX = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MST*`AXI_ID_WIDTH-1:0]       m_arid,
  input  logic [NUM_MST*`AXI_ADDR_WIDTH-1:0]     m_araddr,
  input  logic [NUM_MST*`AXI_LEN_WIDTH-1:0]      m_arlen,
  input  logic [NUM_MST*`AXI_SIZE_WIDTH-1:0]     m_arsize,
  input  logic [NUM_MST*`AXI_BURST_WIDTH-1:0]    m_arburst,
  input  logic [NUM_MST-1:0]                     m_arvalid,
  output logic [NUM_MST-1:0]                     m_arready,
  output logic [`AXI_ID_WIDTH-1:0]               m_rid,
  output logic [`AXI_DATA_WIDTH-1:0]             m_rdata,
  output logic [`AXI_RESP_WIDTH-1:0]             m_rresp,
  output logic                                   m_rlast,
  output logic [NUM_MST-1:0]                     m_rvalid,
  input  logic [NUM_MST-1:0]                     m_rready,
  output logic [SEL_W+`AXI_ID_WIDTH-1:0]         s_arid,
  output logic [`AXI_ADDR_WIDTH-1:0]             s_araddr,
  output logic [`AXI_LEN_WIDTH-1:0]              s_arlen,
  output logic [`AXI_SIZE_WIDTH-1:0]             s_arsize,
  output logic [`AXI_BURST_WIDTH-1:0]            s_arburst,
  output logic                                   s_arvalid,
  input  logic                                   s_arready,
  input  logic [SEL_W+`AXI_ID_WIDTH-1:0]         s_rid,
  input  logic [`AXI_DATA_WIDTH-1:0]             s_rdata,
  input  logic [`AXI_RESP_WIDTH-1:0]             s_rresp,
  input  logic                                   s_rlast,
  input  logic                                   s_rvalid,
  output logic                                   s_rready,
  output logic                                   route_err,
  output logic                                   idle
);
  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid and ready are both 1; valid never waits on ready, payload holds while valid.
  localparam int IDW   = `AXI_ID_WIDTH;
  localparam int AW    = `AXI_ADDR_WIDTH;
  localparam int LW    = `AXI_LEN_WIDTH;
  localparam int SW    = `AXI_SIZE_WIDTH;
  localparam int BW    = `AXI_BURST_WIDTH;
  localparam int CNT_W = $clog2(OST_MAX + 1);

  logic                 load_en;
  logic                 ar_hs;
  logic [NUM_MST-1:0]   grant;
  logic [SEL_W-1:0]     gidx;
  logic [SEL_W-1:0]     rr_ptr;
  logic [SEL_W-1:0]     r_idx;
  logic                 bad_idx;
  logic                 r_last_hs;
  logic [NUM_MST-1:0]   cnt_inc;
  logic [NUM_MST-1:0]   cnt_dec;
  logic [CNT_W-1:0]     ost_cnt [NUM_MST];
  logic [CNT_W-1:0]     ost_nxt [NUM_MST];
  logic                 arvalid_nxt;
  logic                 idle_nxt;

  assign load_en = ~s_arvalid | s_arready;

  // First eligible master at or above rr_ptr, wrapping around.
  always_comb begin
    int  j;
    logic found;
    j     = 0;
    found = 1'b0;
    grant = '0;
    gidx  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      j = (int'(rr_ptr) + i) % NUM_MST;
      if (!found && m_arvalid[j] && (ost_cnt[j] < CNT_W'(OST_MAX))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gidx     = SEL_W'(j);
      end
    end
  end

  assign m_arready = grant & {NUM_MST{load_en}};
  assign ar_hs     = |m_arready;

  assign r_idx     = s_rid[SEL_W+IDW-1 -: SEL_W];
  assign bad_idx   = int'(r_idx) >= NUM_MST;
  assign m_rid     = s_rid[IDW-1:0];
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign m_rlast   = s_rlast;

  // Unroutable beats are accepted and dropped so the downstream never stalls.
  always_comb begin
    m_rvalid = '0;
    s_rready = 1'b1;
    for (int k = 0; k < NUM_MST; k++) begin
      if (!bad_idx && (r_idx == SEL_W'(k))) begin
        m_rvalid[k] = s_rvalid;
        s_rready    = m_rready[k];
      end
    end
  end

  assign r_last_hs = s_rvalid & s_rready & s_rlast;

  always_comb begin
    for (int k = 0; k < NUM_MST; k++) begin
      cnt_inc[k] = m_arready[k];
      cnt_dec[k] = r_last_hs & ~bad_idx & (r_idx == SEL_W'(k)) & (ost_cnt[k] != '0);
      ost_nxt[k] = ost_cnt[k];
      if (cnt_inc[k] && !cnt_dec[k])
        ost_nxt[k] = ost_cnt[k] + 1'b1;
      else if (!cnt_inc[k] && cnt_dec[k])
        ost_nxt[k] = ost_cnt[k] - 1'b1;
    end
  end

  assign arvalid_nxt = load_en ? ar_hs : s_arvalid;

  always_comb begin
    idle_nxt = ~arvalid_nxt;
    for (int k = 0; k < NUM_MST; k++)
      if (ost_nxt[k] != '0) idle_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_arvalid <= 1'b0;
      s_arid    <= '0;
      s_araddr  <= '0;
      s_arlen   <= '0;
      s_arsize  <= '0;
      s_arburst <= '0;
      rr_ptr    <= '0;
      route_err <= 1'b0;
      idle      <= 1'b1;
      for (int k = 0; k < NUM_MST; k++) ost_cnt[k] <= '0;
    end else begin
      s_arvalid <= arvalid_nxt;
      if (ar_hs) begin
        s_arid    <= {gidx, m_arid[int'(gidx)*IDW +: IDW]};
        s_araddr  <= m_araddr[int'(gidx)*AW +: AW];
        s_arlen   <= m_arlen[int'(gidx)*LW +: LW];
        s_arsize  <= m_arsize[int'(gidx)*SW +: SW];
        s_arburst <= m_arburst[int'(gidx)*BW +: BW];
        rr_ptr    <= (int'(gidx) == NUM_MST - 1) ? '0 : gidx + 1'b1;
      end
      route_err <= s_rvalid & bad_idx;
      idle      <= idle_nxt;
      for (int k = 0; k < NUM_MST; k++) ost_cnt[k] <= ost_nxt[k];
    end
  end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb (3 masters, 2 outstanding bursts each) with
// AR and R scoreboards fed by the stimulus and drained by a negedge monitor.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

module tb_axi_rd_arb;
  localparam int NUM = 3;
  localparam int OST = 2;
  localparam int SEL = 2;

  logic             clk;
  logic             rst_n;
  logic [NUM*4-1:0]  m_arid;
  logic [NUM*32-1:0] m_araddr;
  logic [NUM*8-1:0]  m_arlen;
  logic [NUM*3-1:0]  m_arsize;
  logic [NUM*2-1:0]  m_arburst;
  logic [NUM-1:0]    m_arvalid;
  logic [NUM-1:0]    m_arready;
  logic [3:0]        m_rid;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic [NUM-1:0]    m_rvalid;
  logic [NUM-1:0]    m_rready;
  logic [5:0]        s_arid;
  logic [31:0]       s_araddr;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic              s_arvalid;
  logic              s_arready;
  logic [5:0]        s_rid;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              s_rvalid;
  logic              s_rready;
  logic              route_err;
  logic              idle;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [50:0] ar_exp_q[$];
  logic [38:0] r_exp_q[$];

  axi_rd_arb #(.NUM_MST(NUM), .SEL_W(SEL), .OST_MAX(OST)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .route_err(route_err), .idle(idle)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    m_arvalid = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    m_rready  = '1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic set_ar(input int k, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    m_arid[k*4 +: 4]     = id;
    m_araddr[k*32 +: 32] = addr;
    m_arlen[k*8 +: 8]    = len;
    m_arsize[k*3 +: 3]   = 3'd2;
    m_arburst[k*2 +: 2]  = 2'd1;
  endtask

  function automatic logic [50:0] ar_item(input int k, input logic [3:0] id,
                                          input logic [31:0] addr, input logic [7:0] len);
    return {2'(k), id, addr, len, 3'd2, 2'd1};
  endfunction

  // Drives one routable R beat for a single cycle; m_rready must be high.
  task automatic r_beat(input int idx, input logic [3:0] id, input logic [31:0] data,
                        input logic last);
    s_rid    = {2'(idx), id};
    s_rdata  = data;
    s_rresp  = 2'b00;
    s_rlast  = last;
    s_rvalid = 1'b1;
    r_exp_q.push_back({2'(idx), id, data, last});
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_arvalid && s_arready) begin
        check("ar_q_avail", 64'(ar_exp_q.size() > 0), 64'd1);
        if (ar_exp_q.size() > 0)
          check("ar_payload", 64'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}),
                64'(ar_exp_q.pop_front()));
      end
      if ((m_rvalid & m_rready) != '0) begin
        logic [1:0]  got_idx;
        logic [38:0] e;
        got_idx = '0;
        for (int k = 0; k < NUM; k++) if (m_rvalid[k]) got_idx = 2'(k);
        check("r_q_avail", 64'(r_exp_q.size() > 0), 64'd1);
        if (r_exp_q.size() > 0) begin
          e = r_exp_q.pop_front();
          check("r_onehot", 64'(m_rvalid), 64'(3'b001 << e[38:37]));
          check("r_beat", 64'({got_idx, m_rid, m_rdata, m_rlast}), 64'(e));
        end
      end
    end
  end

  initial begin
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    s_rid = '0; s_rdata = '0; s_rresp = '0;
    rst_n = 1'b0; m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    m_rready = '1;

    // Reset values
    #12;
    check("rst_arvalid", 64'(s_arvalid), 64'd0);
    check("rst_arid", 64'(s_arid), 64'd0);
    check("rst_araddr", 64'(s_araddr), 64'd0);
    check("rst_arready", 64'(m_arready), 64'd0);
    check("rst_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_route_err", 64'(route_err), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    do_reset();

    // Single master 0, ARID 3, addr 0x10, len 7
    set_ar(0, 4'd3, 32'h10, 8'd7);
    m_arvalid = 3'b001;
    s_arready = 1'b1;
    ar_exp_q.push_back(ar_item(0, 4'd3, 32'h10, 8'd7));
    #1 check("t1_arready", 64'(m_arready), 64'b001);
    tick();
    m_arvalid = '0;
    #1;
    check("t1_arvalid", 64'(s_arvalid), 64'd1);
    check("t1_arid", 64'(s_arid), 64'h03);
    check("t1_idle_busy", 64'(idle), 64'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      s_rid = {2'd0, 4'd3}; s_rdata = 32'hA000_0000 + 32'(i); s_rresp = 2'b00;
      s_rlast = (i == 7); s_rvalid = 1'b1;
      r_exp_q.push_back({2'd0, 4'd3, 32'hA000_0000 + 32'(i), 1'(i == 7)});
      #1 check("t1_rvalid", 64'(m_rvalid), 64'b001);
      if (i == 7) check("t1_idle_before_last", 64'(idle), 64'd0);
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1 check("t1_idle_after", 64'(idle), 64'd1);

    // Round robin, one grant per cycle, until every master hits its limit
    do_reset();
    for (int k = 0; k < NUM; k++) set_ar(k, 4'(k + 5), 32'h100 * 32'(k + 1), 8'(k));
    m_arvalid = 3'b111;
    s_arready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      ar_exp_q.push_back(ar_item(n % 3, 4'(n % 3 + 5), 32'h100 * 32'(n % 3 + 1), 8'(n % 3)));
      #1 check("rr_grant", 64'(m_arready), 64'(3'b001 << (n % 3)));
      tick();
    end
    #1 check("ost_all_full", 64'(m_arready), 64'd0);
    r_beat(2, 4'd7, 32'h2222, 1'b1);
    ar_exp_q.push_back(ar_item(2, 4'd7, 32'h300, 8'd2));
    #1 check("ost_m2_regrant", 64'(m_arready), 64'b100);
    tick();
    #1 check("ost_m1_blocked", 64'(m_arready), 64'd0);
    r_beat(1, 4'd6, 32'h1111, 1'b1);
    ar_exp_q.push_back(ar_item(1, 4'd6, 32'h200, 8'd1));
    #1 check("ost_m1_regrant", 64'(m_arready), 64'b010);
    tick();
    m_arvalid = '0;
    tick();

    // Downstream stall: register holds, no upstream ready
    do_reset();
    #1 check("mid_reset_idle", 64'(idle), 64'd1);
    set_ar(0, 4'hA, 32'h200, 8'd3);
    set_ar(1, 4'hB, 32'h300, 8'd1);
    m_arvalid = 3'b001;
    ar_exp_q.push_back(ar_item(0, 4'hA, 32'h200, 8'd3));
    #1 check("stall_first", 64'(m_arready), 64'b001);
    tick();
    m_arvalid = 3'b010;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("stall_arvalid", 64'(s_arvalid), 64'd1);
      check("stall_payload", 64'({s_arid, s_araddr}), 64'({6'h0A, 32'h200}));
      check("stall_arready", 64'(m_arready), 64'd0);
      tick();
    end
    s_arready = 1'b1;
    ar_exp_q.push_back(ar_item(1, 4'hB, 32'h300, 8'd1));
    #1 check("unstall_grant", 64'(m_arready), 64'b010);
    tick();
    m_arvalid = '0;
    #1 check("reload_arvalid", 64'(s_arvalid), 64'd1);
    tick();
    #1 check("drain_arvalid", 64'(s_arvalid), 64'd0);

    // Same-cycle accept and rlast for master 2; rlast at count 0 first
    do_reset();
    s_arready = 1'b1;
    r_beat(2, 4'd2, 32'h5555, 1'b1);
    set_ar(2, 4'd2, 32'h400, 8'd0);
    m_arvalid = 3'b100;
    ar_exp_q.push_back(ar_item(2, 4'd2, 32'h400, 8'd0));
    #1 check("no_underflow", 64'(m_arready), 64'b100);
    tick();
    ar_exp_q.push_back(ar_item(2, 4'd2, 32'h400, 8'd0));
    s_rid = {2'd2, 4'd2}; s_rdata = 32'h6666; s_rlast = 1'b1; s_rvalid = 1'b1;
    r_exp_q.push_back({2'd2, 4'd2, 32'h6666, 1'b1});
    #1 check("same_arready", 64'(m_arready), 64'b100);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    ar_exp_q.push_back(ar_item(2, 4'd2, 32'h400, 8'd0));
    #1 check("same_cnt_kept", 64'(m_arready), 64'b100);
    tick();
    #1 check("same_cnt_full", 64'(m_arready), 64'd0);
    m_arvalid = '0;
    tick();

    // Unroutable beat (idx 3) and per-master backpressure
    s_rid = {2'd3, 4'h5}; s_rdata = 32'hDEAD; s_rlast = 1'b1; s_rvalid = 1'b1;
    m_rready = '0;
    #1;
    check("bad_rready", 64'(s_rready), 64'd1);
    check("bad_rvalid", 64'(m_rvalid), 64'd0);
    check("bad_no_pulse_yet", 64'(route_err), 64'd0);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '1;
    m_arvalid = 3'b100;
    #1;
    check("route_err_pulse", 64'(route_err), 64'd1);
    check("bad_cnt_kept", 64'(m_arready), 64'd0);
    tick();
    m_arvalid = '0;
    #1 check("route_err_clear", 64'(route_err), 64'd0);
    s_rid = {2'd2, 4'h1}; s_rlast = 1'b0; s_rvalid = 1'b1; m_rready = 3'b011;
    #1;
    check("bp_rready", 64'(s_rready), 64'd0);
    check("bp_rvalid", 64'(m_rvalid), 64'b100);
    tick();
    s_rvalid = 1'b0; m_rready = '1;
    repeat (2) tick();

    check("ar_q_empty", 64'(ar_exp_q.size()), 64'd0);
    check("r_q_empty", 64'(r_exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
